// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor stage
// plus a registered borrow. An operation takes WIDTH cycles in RUN followed by
// a single DONE cycle. diff/borrow_out hold until the next operation completes.
// Optional build macro: SERIAL_SUB_OVERFLOW_EN adds a signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             bit_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Full-subtractor difference bit
    function automatic logic fs_diff(input logic ai, input logic bi, input logic br);
        return ai ^ bi ^ br;
    endfunction

    // Full-subtractor borrow out
    function automatic logic fs_borrow(input logic ai, input logic bi, input logic br);
        return (~ai & bi) | (~(ai ^ bi) & br);
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic d_s;
    logic bnext_s;

    // Current serial stage computed from the operand LSBs and the borrow flop
    always_comb begin
        d_s     = fs_diff(a_sr_q[0], b_sr_q[0], br_q);
        bnext_s = fs_borrow(a_sr_q[0], b_sr_q[0], br_q);
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        br_d         = br_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        ovf_d        = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                res_d  = {d_s, res_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                br_d   = bnext_s;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the result on the DONE-entry edge
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    diff_d       = {d_s, res_q[WIDTH-1:1]};
                    borrow_out_d = bnext_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d        = (a_msb_q ^ b_msb_q) & (d_s ^ a_msb_q);
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_sr_q       <= {WIDTH{1'b0}};
            b_sr_q       <= {WIDTH{1'b0}};
            res_q        <= {WIDTH{1'b0}};
            cnt_q        <= {CW{1'b0}};
            br_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= {WIDTH{1'b0}};
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            br_q         <= br_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign ovf        = ovf_q;
`endif
    // Probe bit is only meaningful while running; forced low otherwise
    assign bit_out    = (state_q == ST_RUN) ? d_s : 1'b0;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors,
// expected results queued at issue time and popped by a done-driven monitor.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         bit_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .ovf        (ovf),
`endif
        .bit_out    (bit_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an operation; the accepting edge is the next rising edge
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic push, input exp_t e);
        start = 1'b1;
        a     = av;
        b     = bv;
        if (push) exp_q.push_back(e);
        tick();
        start = 1'b0;
    endtask

    // Walk RUN cycles 1..W checking busy and the serial bit, then the done cycle.
    // inject>0 pulses start with other operands during that RUN cycle.
    task automatic wait_run(input logic [W-1:0] bits, input int inject);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            check("busy_run", {15'd0, busy}, 16'd1);
            check("done_early", {15'd0, done}, 16'd0);
            check("bit_out", {15'd0, bit_out}, {15'd0, bits[i-1]});
            if (i == inject) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end
            tick();
            start = 1'b0;
        end
        @(negedge clk);
        check("done_pulse", {15'd0, done}, 16'd1);
        check("busy_done", {15'd0, busy}, 16'd0);
    endtask

    // One cycle after DONE with no restart: done must drop, result must hold
    task automatic after_done(input logic [W-1:0] dv, input logic brv);
        tick();
        @(negedge clk);
        check("done_single", {15'd0, done}, 16'd0);
        check("busy_idle", {15'd0, busy}, 16'd0);
        check("diff_hold", {8'd0, diff}, {8'd0, dv});
        check("borrow_hold", {15'd0, borrow_out}, {15'd0, brv});
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 with diff 0x%0h, expected no completion", diff);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_diff", {8'd0, diff}, {8'd0, e.d});
                check("sb_borrow", {15'd0, borrow_out}, {15'd0, e.br});
`ifdef SERIAL_SUB_OVERFLOW_EN
                check("sb_ovf", {15'd0, ovf}, {15'd0, e.ov});
`endif
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_diff", {8'd0, diff}, 16'd0);
        check("rst_borrow", {15'd0, borrow_out}, 16'd0);
        check("rst_bit_out", {15'd0, bit_out}, 16'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("rst_ovf", {15'd0, ovf}, 16'd0);
`endif
        rst = 1'b0;
        tick();

        // 5 - 3 = 2
        start_op(8'h05, 8'h03, 1'b1, '{d: 8'h02, br: 1'b0, ov: 1'b0});
        wait_run(8'h02, 0);
        after_done(8'h02, 1'b0);

        // 3 - 5 = 0xFE with borrow; serial bits 0,1,1,1,1,1,1,1
        start_op(8'h03, 8'h05, 1'b1, '{d: 8'hFE, br: 1'b1, ov: 1'b0});
        wait_run(8'hFE, 0);
        after_done(8'hFE, 1'b1);

        // 0 - 0, then restart in the DONE cycle with 0xFF - 0x01
        start_op(8'h00, 8'h00, 1'b1, '{d: 8'h00, br: 1'b0, ov: 1'b0});
        wait_run(8'h00, 0);
        start_op(8'hFF, 8'h01, 1'b1, '{d: 8'hFE, br: 1'b0, ov: 1'b0});
        wait_run(8'hFE, 0);
        after_done(8'hFE, 1'b0);

        // start during RUN (cycle 4) is ignored
        start_op(8'h10, 8'h01, 1'b1, '{d: 8'h0F, br: 1'b0, ov: 1'b0});
        wait_run(8'h0F, 4);
        after_done(8'h0F, 1'b0);
        repeat (12) tick();

        // Reset in cycle 5 aborts; no done, outputs cleared
        start_op(8'h40, 8'h20, 1'b0, '{d: 8'h00, br: 1'b0, ov: 1'b0});
        repeat (4) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_diff", {8'd0, diff}, 16'd0);
        check("abort_bit_out", {15'd0, bit_out}, 16'd0);
        rst = 1'b0;
        repeat (12) tick();
        check("abort_no_done", {15'd0, done}, 16'd0);

        // Normal op after abort
        start_op(8'h40, 8'h20, 1'b1, '{d: 8'h20, br: 1'b0, ov: 1'b0});
        wait_run(8'h20, 0);
        after_done(8'h20, 1'b0);

        // Signed-overflow vectors (diff/borrow checked in every build)
        start_op(8'h80, 8'h01, 1'b1, '{d: 8'h7F, br: 1'b0, ov: 1'b1});
        wait_run(8'h7F, 0);
        after_done(8'h7F, 1'b0);
        start_op(8'h7F, 8'h01, 1'b1, '{d: 8'h7E, br: 1'b0, ov: 1'b0});
        wait_run(8'h7E, 0);
        after_done(8'h7E, 1'b0);

        repeat (12) tick();
        check("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor core: computes diff = a - b over WIDTH clock cycles, LSB first, one full-subtractor stage plus a registered borrow.
- Inverse arithmetic counterpart to the combinational adder cell in the same tile.
- Sits behind the tile's ui_in/uio_in operand capture logic and drives uo_out through the top wrapper.
- Start/busy/done handshake; the result holds until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend, captured on the accepting edge
- b  input  WIDTH  subtrahend, captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse when the result becomes valid
- diff  output  WIDTH  a - b modulo 2^WIDTH; valid from done until the next accepted start
- borrow_out  output  1  final borrow; 1 iff a < b unsigned
- bit_out  output  1  current serial difference bit, for probing; meaningful only while busy=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge.
- On reset: state=IDLE; busy=0, done=0, diff=0, borrow_out=0, bit_out=0. Internal shift registers, borrow flop and bit counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures a and b into the shift registers, clears the borrow flop and the counter, goes to RUN.
  - start=0 stays in IDLE.
- RUN, each cycle:
  - ai = a_sr[0], bi = b_sr[0], br = borrow flop.
  - d = ai ^ bi ^ br.
  - borrow_next = (~ai & bi) | (~(ai ^ bi) & br).
  - Shift a_sr and b_sr right by one; shift d into the MSB of the result register.
  - counter increments.
  - bit_out = d (combinational from the current LSBs).
  - After the WIDTH-th bit, go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - diff = result register; borrow_out = final borrow.
  - start=1 here is accepted exactly as in IDLE and goes to RUN; otherwise go to IDLE.
- Latency: start accepted at edge 0 -> busy=1 during cycles 1..WIDTH -> done=1 in cycle WIDTH+1.
- Back-to-back throughput: one op per WIDTH+1 cycles.
- start during RUN is ignored: no capture, no queueing.
- diff and borrow_out change only on the DONE-entry edge. Between done and the next completion they hold, including across IDLE.
- Reset mid-operation aborts immediately. All outputs take their reset values on the next edge, and there is no done pulse.
- rst and start in the same cycle: reset wins.
- Counter width is $clog2(WIDTH+1); no wrap occurs within an operation.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, updated on the same edge as diff.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), i.e. two's-complement signed overflow.
  - The MSB operand bits are taken from registered copies captured at start.
- Not defined: no ovf port, no extra registers; all other behaviour is identical.

Test Plan:
- WIDTH=8, start with a=0x05, b=0x03 -> busy for cycles 1..8, done in cycle 9, diff=0x02, borrow_out=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; bit_out sequence LSB-first 0,1,1,1,1,1,1,1.
- a=0x00,b=0x00 then back-to-back start in the DONE cycle with a=0xFF,b=0x01:
  - first op: diff=0x00, borrow_out=0;
  - second op: done 9 cycles later, diff=0xFE, borrow_out=0.
- start pulsed at cycle 4 of a running a=0x10,b=0x01 op with a=0xAA,b=0x55 -> ignored; diff=0x0F, borrow_out=0, and no second done.
- rst asserted at cycle 5 of a=0x40,b=0x20 -> next edge: busy=0, diff=0, no done pulse; the next start then runs normally.
- With SERIAL_SUB_OVERFLOW_EN:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow_out=0.
  - a=0x7F, b=0x01 -> diff=0x7E, ovf=0.
